// File: rtl/enc_pipeline.sv
// enc_pipeline: parametrised multi-stage encryption pipeline.
//
// Each of STAGES round registers holds one item together with its own copy of
// the key bundle and the encrypt/decrypt mode. Because of this, key or mode
// changes at the input never disturb items that are already in flight. Every
// stage boundary uses a valid/ready handshake, so empty stages (bubbles)
// collapse and a full pipeline stalls cleanly under output backpressure.
//
// Round for stage i, using sub-key index j:
//   m_j = k_j replicated from the LSB up to DATA_W bits
//   s_j = k_j mod DATA_W
//   encrypt: j = i,          result = rotl(x ^ m_j, s_j)
//   decrypt: j = STAGES-1-i, result = rotr(x, s_j) ^ m_j
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (has priority over flush)
//   flush      synchronous clear of all stage valid bits
//   in_valid   input item valid
//   in_ready   pipeline can accept an item this cycle
//   in_data    plaintext or ciphertext
//   in_decrypt 0 = encrypt, 1 = decrypt (captured per item)
//   key_bits   sub-keys, k_j = key_bits[j*KEYB +: KEYB] (captured per item)
//   out_valid  output item valid
//   out_ready  consumer accepts the output item
//   out_data   result
//   occupancy  number of valid stage registers
module enc_pipeline #(
  parameter int DATA_W = 16,
  parameter int STAGES = 3,
  parameter int KEYB   = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_decrypt,
  input  logic [STAGES*KEYB-1:0]       key_bits,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int KEY_W = STAGES * KEYB;
  localparam int OCC_W = $clog2(STAGES + 1);

  // One round; the sub-key index depends on the item's mode so that the
  // decrypt chain undoes the encrypt rounds in reverse order.
  function automatic logic [DATA_W-1:0] round_fn(
    input logic [DATA_W-1:0] x,
    input logic [KEY_W-1:0]  keys,
    input logic              dec,
    input int                stage
  );
    int                  j;
    int                  s;
    logic [KEYB-1:0]     k;
    logic [DATA_W-1:0]   m;
    logic [DATA_W-1:0]   res;
    logic [2*DATA_W-1:0] dbl;
    j = dec ? (STAGES - 1 - stage) : stage;
    k = keys[j*KEYB +: KEYB];
    for (int b = 0; b < DATA_W; b++) begin
      m[b] = k[b % KEYB];
    end
    s = int'(k) % DATA_W;
    // Rotations are done on a doubled word so a variable shift suffices.
    if (!dec) begin
      dbl = {x ^ m, x ^ m} << s;
      res = dbl[2*DATA_W-1 -: DATA_W];
    end else begin
      dbl = {x, x} >> s;
      res = dbl[DATA_W-1:0] ^ m;
    end
    return res;
  endfunction

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] nxt_v;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] mode_r;
  logic [STAGES-1:0] src_mode;
  logic [STAGES-1:0] src_v;
  logic [STAGES:0]   ready;
  logic [DATA_W-1:0] d       [STAGES];
  logic [DATA_W-1:0] src_d   [STAGES];
  logic [DATA_W-1:0] rnd     [STAGES];
  logic [KEY_W-1:0]  key_r   [STAGES];
  logic [KEY_W-1:0]  src_key [STAGES];

  // Ready chain. ready_i = !v_i || ready_{i+1} unrolls to "some stage at or
  // after i is empty, or the consumer is taking the output", which is built
  // here from a running AND so no signal depends on itself.
  always_comb begin
    logic full_run;
    full_run      = 1'b1;
    ready         = '0;
    ready[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      full_run = full_run & v[i];
      ready[i] = !full_run || out_ready;
    end
  end

  assign in_ready = ready[0] && !flush;

  // Stage sources, round results and load/hold decisions. Loads are blocked
  // during flush so the data registers stay unchanged in that cycle.
  always_comb begin
    src_d[0]    = in_data;
    src_key[0]  = key_bits;
    src_mode[0] = in_decrypt;
    src_v[0]    = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      src_d[i]    = d[i-1];
      src_key[i]  = key_r[i-1];
      src_mode[i] = mode_r[i-1];
      src_v[i]    = v[i-1];
    end
    for (int i = 0; i < STAGES; i++) begin
      rnd[i]   = round_fn(src_d[i], src_key[i], src_mode[i], i);
      load[i]  = src_v[i] && ready[i] && !flush;
      nxt_v[i] = load[i] || (v[i] && !ready[i+1]);
    end
  end

  // Stage registers; reset wins over flush, flush only clears valid bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      v      <= '0;
      mode_r <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i]     <= '0;
        key_r[i] <= '0;
      end
    end else begin
      v <= flush ? '0 : nxt_v;
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          d[i]      <= rnd[i];
          key_r[i]  <= src_key[i];
          mode_r[i] <= src_mode[i];
        end
      end
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      if (v[i]) begin
        occupancy = occupancy + OCC_W'(1);
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];

endmodule

// File: doc/enc_pipeline.md
Name: enc_pipeline

Overview:
- Parametrised single-clock successor to the fixed three-stage encryption chain.
- Runs STAGES round registers, with a valid/ready handshake at every stage boundary and per-item encrypt/decrypt mode.
- Key and mode travel with each item, so key changes never corrupt in-flight data.
- Provides occupancy reporting and a synchronous flush. Sits between the input data source and the output consumer.

Parameters:
- DATA_W, 16, datapath width in bits (>=2).
- STAGES, 3, number of round stages (>=1).
- KEYB, 6, sub-key bits per stage.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous pipeline clear.
- in_valid  input  1  input item valid.
- in_ready  output  1  pipeline can accept an input item.
- in_data  input  DATA_W  plaintext or ciphertext.
- in_decrypt  input  1  0 = encrypt, 1 = decrypt (per item).
- key_bits  input  STAGES*KEYB  sub-keys; k_j = key_bits[j*KEYB +: KEYB].
- out_valid  output  1  output item valid.
- out_ready  input  1  consumer accepts the output item.
- out_data  output  DATA_W  result.
- occupancy  output  $clog2(STAGES+1)  number of valid stage registers.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all stage valid bits 0, all stage data/key/mode registers 0, occupancy 0, out_valid 0, out_data 0.
- Stage i (0..STAGES-1) register set: v_i, d_i, key copy, mode copy. Stage 0 loads from the input ports; stage i loads from stage i-1.
- Load rule: stage i loads when its predecessor is valid and (!v_i or stage i is advancing).
  - Last stage advances when out_ready=1.
  - ready_i = !v_i || ready_{i+1}; ready_{STAGES} = out_ready.
  - in_ready = ready_0 && !flush.
  - The ready chain is combinational.
- On a load with no downstream acceptance of the loading stage's old value, bubbles collapse: a stage with v_i=0 always accepts.
- Transfer at the input: in_valid && in_ready. Transfer at the output: out_valid && out_ready.
- out_valid = v_{STAGES-1}; out_data = d_{STAGES-1}.
- Latency: STAGES cycles from input transfer to out_valid when there is no backpressure. Throughput is 1 item/cycle.
- Round function for stage i processing sub-key index j:
  - m_j = k_j replicated from the LSB to DATA_W bits, truncated.
  - s_j = k_j mod DATA_W.
  - Encrypt: j = i; result = rotl(x XOR m_j, s_j).
  - Decrypt: j = STAGES-1-i; result = rotr(x, s_j) XOR m_j.
  - The result is computed on entry and registered into stage i.
- Key and mode are sampled together with in_data at the input transfer and shifted with the item. A later key_bits/in_decrypt change does not affect in-flight items.
- Invariant: decrypt(encrypt(x, K), K) = x for all x and K.
- Backpressure: when out_ready=0 and every stage is valid, all registers hold and in_ready=0. No item is dropped or duplicated.
- occupancy = count of v_i set, registered/consistent with the current valid bits. Range 0..STAGES.
- flush=1: all v_i cleared next cycle; data registers unchanged; in_ready=0 that cycle so no input is accepted. Flush overrides simultaneous in_valid and out_ready, and the output transfer in that cycle still counts if out_valid && out_ready.
- rst has priority over flush.
- Reset mid-stream discards all in-flight items; the first post-reset input behaves as in an empty pipeline.
- in_ready may be high while in_valid=0; no load occurs in that case.

Test Plan:
- Reset with in_valid=1 asserted -> out_valid=0, out_data=0x0000, occupancy=0, no item emitted.
- Defaults, key_bits={k2=3,k1=2,k0=1}, encrypt in_data=0x0000, out_ready=1 -> out_data=0x8619 with out_valid high exactly 3 cycles after the transfer.
- Same key, decrypt in_data=0x8619 -> out_data=0x0000. key_bits=0, encrypt 0xBEEF -> 0xBEEF.
- Stream 5 items with out_ready=0 -> exactly 3 accepted, in_ready=0, occupancy=3. Raise out_ready -> items emerge in order, one per cycle, none lost or duplicated.
- Change key_bits and in_decrypt every cycle while streaming random data -> each output matches the reference model using that item's own captured key and mode.
- Assert flush with occupancy=3 and in_valid=1 -> next cycle occupancy=0 and out_valid=0, the flush-cycle input is not accepted, and the next input yields a correct result after 3 cycles.
